// File: rtl/apb2axi_pkg.sv
// ============================================================================
// Module   : apb2axi_pkg
// Purpose  : Shared types and helpers for the APB-to-AXI read return path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb2axi_pkg;

    localparam int CPL_ID_W  = 4;
    localparam int CPL_LEN_W = 4;
    localparam int NUM_TAGS  = 2 ** CPL_ID_W;
    localparam int MAX_BEATS = 2 ** CPL_LEN_W;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } rresp_e;

    typedef struct packed {
        logic [CPL_ID_W-1:0]  tag;
        rresp_e               resp;
        logic [CPL_LEN_W:0]   beats;
        logic                 len_err;
    } rd_cpl_t;

    // EXOKAY folds to OKAY so the numeric encoding gives the error priority.
    function automatic rresp_e resp_merge(input rresp_e a, input rresp_e b);
        rresp_e na;
        rresp_e nb;
        na = (a == EXOKAY) ? OKAY : a;
        nb = (b == EXOKAY) ? OKAY : b;
        return (na > nb) ? na : nb;
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb2axi_rdata_ram.sv
// ============================================================================
// Module   : apb2axi_rdata_ram
// Purpose  : Simple dual-port read-data buffer, registered read-first port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb2axi_rdata_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge aclk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Same-edge write is not yet visible here, giving read-first behaviour.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rdata <= '0;
        end else if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/apb2axi_read_collector.sv
// ============================================================================
// Module   : apb2axi_read_collector
// Purpose  : Collects AXI R beats per tag into a buffer and emits completions.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb2axi_read_collector
    import apb2axi_pkg::*;
#(
    parameter int AXI_ID_W   = 4,
    parameter int AXI_DATA_W = 64,
    parameter int LEN_W      = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  ar_fire,
    input  logic [AXI_ID_W-1:0]   ar_tag,
    input  logic [LEN_W-1:0]      ar_len,
    input  logic [AXI_ID_W-1:0]   rid,
    input  logic [AXI_DATA_W-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic                  cpl_valid,
    input  logic                  cpl_ready,
    output logic [AXI_ID_W-1:0]   cpl_tag,
    output logic [1:0]            cpl_resp,
    output logic [LEN_W:0]        cpl_beats,
    output logic                  cpl_len_err,
    input  logic                  buf_rd_en,
    input  logic [AXI_ID_W-1:0]   buf_rd_tag,
    input  logic [LEN_W-1:0]      buf_rd_beat,
    output logic [AXI_DATA_W-1:0] buf_rd_data,
    output logic                  err_unexp
);

    localparam int N_TAGS = 2 ** AXI_ID_W;

    logic [N_TAGS-1:0] r_outst;
    logic [LEN_W-1:0]  r_exp_len [N_TAGS];
    logic [LEN_W:0]    r_cnt     [N_TAGS];
    rresp_e            r_resp    [N_TAGS];

    rd_cpl_t r_cpl;
    logic    r_cpl_valid;
    logic    r_rready;
    logic    r_err;

    logic             w_accept;
    logic             w_hit;
    logic [LEN_W-1:0] w_idx;
    logic             w_at_len;
    logic             w_end;
    logic             w_len_err;
    logic [LEN_W:0]   w_beats;
    rresp_e           w_merged;
    logic             w_ar_busy;
    logic             w_cpl_valid_nxt;

    assign w_accept  = rvalid && r_rready;
    assign w_hit     = w_accept && r_outst[rid];
    assign w_idx     = r_cnt[rid][LEN_W-1:0];
    assign w_at_len  = (w_idx == r_exp_len[rid]);
    assign w_end     = w_hit && (rlast || w_at_len);
    assign w_len_err = rlast ? !w_at_len : w_at_len;
    assign w_beats   = r_cnt[rid] + (LEN_W+1)'(1);
    assign w_merged  = resp_merge(r_resp[rid], rresp_e'(rresp));
    assign w_ar_busy = ar_fire && r_outst[ar_tag];

    // rready is low whenever the slot is full, so no new end can collide with a held one.
    assign w_cpl_valid_nxt = r_cpl_valid ? !cpl_ready : w_end;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_outst     <= '0;
            for (int i = 0; i < N_TAGS; i++) begin
                r_exp_len[i] <= '0;
                r_cnt[i]     <= '0;
                r_resp[i]    <= OKAY;
            end
            r_cpl       <= '0;
            r_cpl_valid <= 1'b0;
            r_rready    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            for (int i = 0; i < N_TAGS; i++) begin
                if (ar_fire && !r_outst[i] && (ar_tag == AXI_ID_W'(i))) begin
                    r_outst[i]   <= 1'b1;
                    r_exp_len[i] <= ar_len;
                    r_cnt[i]     <= '0;
                    r_resp[i]    <= OKAY;
                end
                if (w_hit && (rid == AXI_ID_W'(i))) begin
                    r_cnt[i]  <= w_beats;
                    r_resp[i] <= w_merged;
                    if (w_end) begin
                        r_outst[i] <= 1'b0;
                    end
                end
            end
            if (w_end) begin
                r_cpl.tag     <= rid;
                r_cpl.resp    <= w_merged;
                r_cpl.beats   <= w_beats;
                r_cpl.len_err <= w_len_err;
            end
            r_cpl_valid <= w_cpl_valid_nxt;
            r_rready    <= !w_cpl_valid_nxt;
            r_err       <= w_ar_busy || (w_accept && !r_outst[rid]);
        end
    end

    apb2axi_rdata_ram #(
        .ADDR_W (AXI_ID_W + LEN_W),
        .DATA_W (AXI_DATA_W)
    ) u_ram (
        .aclk    (aclk),
        .aresetn (aresetn),
        .we      (w_hit),
        .waddr   ({rid, w_idx}),
        .wdata   (rdata),
        .re      (buf_rd_en),
        .raddr   ({buf_rd_tag, buf_rd_beat}),
        .rdata   (buf_rd_data)
    );

    assign rready      = r_rready;
    assign cpl_valid   = r_cpl_valid;
    assign cpl_tag     = r_cpl.tag;
    assign cpl_resp    = r_cpl.resp;
    assign cpl_beats   = r_cpl.beats;
    assign cpl_len_err = r_cpl.len_err;
    assign err_unexp   = r_err;

endmodule

`default_nettype wire
